// File: rtl/uart_slip_decoder.sv
// SLIP (RFC 1055) decoder: UART receiver byte stream in, AXI4-Stream packets out.
// Optional macro SLIP_FRAME_COUNT_EN adds the good_count/bad_count frame counters.
module uart_slip_decoder #(
    parameter int MAX_LEN = 1536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        line_error,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_done,
    output logic        bad_frame,
    output logic [15:0] good_count,
    output logic [15:0] bad_count
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic {
        NORMAL,
        ESCAPED
    } state_t;

    state_t           state, state_next;
    logic [7:0]       hold_data, hold_data_next;
    logic             hold_valid, hold_valid_next;
    logic             bad, bad_next;
    logic [LEN_W-1:0] len, len_next;
    logic [7:0]       out_data_next;
    logic             out_valid_next, out_last_next, out_user_next;
    logic             frame_done_next, bad_frame_next;

    logic             accept;
    logic             close_frame;
    logic             store;
    logic [7:0]       store_byte;
    logic             esc_bad;

    // The output register is always free whenever a byte is accepted.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= NORMAL;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            bad           <= 1'b0;
            len           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_done    <= 1'b0;
            bad_frame     <= 1'b0;
        end else begin
            state         <= state_next;
            hold_data     <= hold_data_next;
            hold_valid    <= hold_valid_next;
            bad           <= bad_next;
            len           <= len_next;
            m_axis_tdata  <= out_data_next;
            m_axis_tvalid <= out_valid_next;
            m_axis_tlast  <= out_last_next;
            m_axis_tuser  <= out_user_next;
            frame_done    <= frame_done_next;
            bad_frame     <= bad_frame_next;
        end
    end

    // Byte classification: decides whether the accepted byte closes the frame or stores data.
    always_comb begin
        state_next  = state;
        close_frame = 1'b0;
        store       = 1'b0;
        store_byte  = s_axis_tdata;
        esc_bad     = 1'b0;
        if (accept) begin
            case (state)
                NORMAL: begin
                    if (s_axis_tdata == SLIP_END) begin
                        close_frame = 1'b1;
                    end else if (s_axis_tdata == SLIP_ESC) begin
                        state_next = ESCAPED;
                    end else begin
                        store = 1'b1;
                    end
                end
                ESCAPED: begin
                    state_next = NORMAL;
                    if (s_axis_tdata == SLIP_ESC_END) begin
                        store      = 1'b1;
                        store_byte = SLIP_END;
                    end else if (s_axis_tdata == SLIP_ESC_ESC) begin
                        store      = 1'b1;
                        store_byte = SLIP_ESC;
                    end else if (s_axis_tdata == SLIP_END) begin
                        close_frame = 1'b1;
                        esc_bad     = 1'b1;
                    end else begin
                        store   = 1'b1;
                        esc_bad = 1'b1;
                    end
                end
                default: state_next = NORMAL;
            endcase
        end
    end

    // Hold register, frame status and output register updates.
    always_comb begin
        hold_data_next  = hold_data;
        hold_valid_next = hold_valid;
        len_next        = len;
        bad_next        = bad || line_error || esc_bad;
        out_data_next   = m_axis_tdata;
        out_valid_next  = m_axis_tvalid && !m_axis_tready;
        out_last_next   = m_axis_tlast;
        out_user_next   = m_axis_tuser;
        frame_done_next = 1'b0;
        bad_frame_next  = 1'b0;

        if (close_frame) begin
            if (hold_valid) begin
                out_valid_next  = 1'b1;
                out_data_next   = hold_data;
                out_last_next   = 1'b1;
                out_user_next   = bad_next;
                frame_done_next = 1'b1;
                bad_frame_next  = bad_next;
            end
            hold_valid_next = 1'b0;
            len_next        = '0;
            bad_next        = 1'b0;
        end else if (store) begin
            if (len == LEN_MAX) begin
                bad_next = 1'b1;
            end else begin
                if (hold_valid) begin
                    out_valid_next = 1'b1;
                    out_data_next  = hold_data;
                    out_last_next  = 1'b0;
                    out_user_next  = 1'b0;
                end
                hold_data_next  = store_byte;
                hold_valid_next = 1'b1;
                len_next        = len + 1'b1;
            end
        end
    end

`ifdef SLIP_FRAME_COUNT_EN
    logic [15:0] good_cnt, bad_cnt;

    // Counters follow the registered pulses and wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (frame_done && !bad_frame) begin
                good_cnt <= good_cnt + 16'd1;
            end
            if (bad_frame) begin
                bad_cnt <= bad_cnt + 16'd1;
            end
        end
    end

    assign good_count = good_cnt;
    assign bad_count  = bad_cnt;
`else
    assign good_count = '0;
    assign bad_count  = '0;
`endif

endmodule

// File: tb/tb_uart_slip_decoder.sv
// Self-checking bench for uart_slip_decoder: directed vector table, hand-written corner
// sequences and randomized traffic against a frame-level SLIP reference model.
module tb_uart_slip_decoder;

    localparam int BIG_LEN   = 1536;
    localparam int SMALL_LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata [2];
    logic [1:0] s_tvalid, s_tready, line_err;
    logic [7:0] m_tdata [2];
    logic [1:0] m_tvalid, m_tlast, m_tuser, fd, bf;
    logic       m_tready;
    logic [15:0] gcnt [2];
    logic [15:0] bcnt [2];

    always #5 clk = ~clk;

    uart_slip_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata[0]),
        .s_axis_tvalid (s_tvalid[0]),
        .s_axis_tready (s_tready[0]),
        .line_error    (line_err[0]),
        .m_axis_tdata  (m_tdata[0]),
        .m_axis_tvalid (m_tvalid[0]),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast[0]),
        .m_axis_tuser  (m_tuser[0]),
        .frame_done    (fd[0]),
        .bad_frame     (bf[0]),
        .good_count    (gcnt[0]),
        .bad_count     (bcnt[0])
    );

    uart_slip_decoder #(.MAX_LEN(SMALL_LEN)) dut_small (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata[1]),
        .s_axis_tvalid (s_tvalid[1]),
        .s_axis_tready (s_tready[1]),
        .line_error    (line_err[1]),
        .m_axis_tdata  (m_tdata[1]),
        .m_axis_tvalid (m_tvalid[1]),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast[1]),
        .m_axis_tuser  (m_tuser[1]),
        .frame_done    (fd[1]),
        .bad_frame     (bf[1]),
        .good_count    (gcnt[1]),
        .bad_count     (bcnt[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ready = 1'b0;

    // Token: bit9 = line_error pulse, bit8 = byte present, [7:0] = byte
    logic [9:0] toks [$];
    logic [9:0] exp_q [$];
    int exp_good, exp_bad;
    int tot_good [2];
    int tot_bad [2];

    logic [9:0] rx0 [$];
    logic [9:0] rx1 [$];
    int n_fd [2];
    int n_bf [2];
    bit stall_prev [2];
    logic [9:0] stall_val [2];

    typedef struct {
        int         sel;
        int         n_in;
        logic [9:0] in_tok [12];
        int         n_out;
        logic [7:0] out_b [4];
        bit         user;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
    endtask

    // Output monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (stall_prev[k])
                checkOutput("stall_stable", {m_tvalid[k], m_tuser[k], m_tlast[k], m_tdata[k]},
                            {1'b1, stall_val[k]});
            stall_prev[k] = !rst && m_tvalid[k] && !m_tready;
            stall_val[k]  = {m_tuser[k], m_tlast[k], m_tdata[k]};
            if (m_tvalid[k] && m_tready) begin
                if (k == 0) rx0.push_back({m_tuser[0], m_tlast[0], m_tdata[0]});
                else        rx1.push_back({m_tuser[1], m_tlast[1], m_tdata[1]});
            end
            if (fd[k]) begin
                n_fd[k]++;
                checkOutput("frame_done_with_tlast", {m_tvalid[k], m_tlast[k]}, 2'b11);
            end
            if (bf[k]) begin
                n_bf[k]++;
                checkOutput("bad_frame_with_frame_done", fd[k], 1);
                checkOutput("bad_frame_with_tuser", m_tuser[k], 1);
            end
        end
    end

    task automatic applyStimulus(input int sel, input logic [9:0] tok);
        int  waited;
        bit  acc;
        waited = 0;
        acc    = 1'b0;
        line_err[sel] = tok[9];
        if (!tok[8]) begin
            tick();
            line_err[sel] = 1'b0;
            return;
        end
        s_tdata[sel]  = tok[7:0];
        s_tvalid[sel] = 1'b1;
        do begin
            @(negedge clk);
            acc = s_tready[sel];
            tick();
            waited++;
        end while (!acc && waited < 200);
        if (!acc) checkOutput("input_accept_timeout", 0, 1);
        s_tvalid[sel] = 1'b0;
        line_err[sel] = 1'b0;
    endtask

    task automatic drain(input int sel);
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        repeat (4) tick();
        checkOutput("drain_idle", m_tvalid[sel], 0);
    endtask

    task automatic sendAll(input int sel);
        foreach (toks[i]) applyStimulus(sel, toks[i]);
        drain(sel);
    endtask

    // Reference model: split the token stream into frames and decode each as a byte list.
    task automatic buildExpected(input int max_len);
        logic [7:0] payload [$];
        bit         bad, esc, is_end, do_store;
        logic [7:0] b, d;
        bad = 0; esc = 0;
        exp_q.delete();
        exp_good = 0;
        exp_bad  = 0;
        foreach (toks[i]) begin
            if (toks[i][9]) bad = 1;
            if (toks[i][8]) begin
                b = toks[i][7:0];
                d = b;
                is_end = 0;
                do_store = 0;
                if (esc) begin
                    esc = 0;
                    if (b == 8'hC0) begin bad = 1; is_end = 1; end
                    else if (b == 8'hDC) begin d = 8'hC0; do_store = 1; end
                    else if (b == 8'hDD) begin d = 8'hDB; do_store = 1; end
                    else begin bad = 1; do_store = 1; end
                end else if (b == 8'hC0) is_end = 1;
                else if (b == 8'hDB) esc = 1;
                else do_store = 1;
                if (do_store) begin
                    if (payload.size() >= max_len) bad = 1;
                    else payload.push_back(d);
                end
                if (is_end) begin
                    if (payload.size() > 0) begin
                        foreach (payload[j])
                            exp_q.push_back({bad && (j == payload.size() - 1),
                                             j == payload.size() - 1, payload[j]});
                        if (bad) exp_bad++;
                        else     exp_good++;
                        payload.delete();
                    end
                    bad = 0;
                end
            end
        end
    endtask

    task automatic compareStream(input int sel, input int base_rx, input int base_fd,
                                 input int base_bf, input string name);
        int got_n;
        logic [9:0] got;
        got_n = ((sel == 0) ? rx0.size() : rx1.size()) - base_rx;
        checkOutput({name, "_count"}, got_n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
            got = (sel == 0) ? rx0[base_rx + i] : rx1[base_rx + i];
            checkOutput(name, got, exp_q[i]);
        end
        checkOutput({name, "_frame_done"}, n_fd[sel] - base_fd, exp_good + exp_bad);
        checkOutput({name, "_bad_frame"}, n_bf[sel] - base_bf, exp_bad);
        tot_good[sel] += exp_good;
        tot_bad[sel]  += exp_bad;
    endtask

    int bx, bfd, bbf, sel;
    logic [7:0] rb;
    int r;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        s_tvalid = '0;
        line_err = '0;
        s_tdata[0] = '0;
        s_tdata[1] = '0;
        m_tready = 1'b1;
        tot_good[0] = 0; tot_good[1] = 0;
        tot_bad[0]  = 0; tot_bad[1]  = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_outputs", {m_tvalid[k], m_tlast[k], m_tuser[k], fd[k], bf[k], m_tdata[k]}, 0);
            checkOutput("reset_s_tready", s_tready[k], 1);
            checkOutput("reset_counts", {gcnt[k], bcnt[k]}, 0);
        end
        tick();

        vecs[0]  = '{0, 5, '{10'h1C0, 10'h101, 10'h102, 10'h103, 10'h1C0, 0, 0, 0, 0, 0, 0, 0}, 3, '{8'h01, 8'h02, 8'h03, 0}, 0};
        vecs[1]  = '{0, 7, '{10'h1C0, 10'h1DB, 10'h1DC, 10'h155, 10'h1DB, 10'h1DD, 10'h1C0, 0, 0, 0, 0, 0}, 3, '{8'hC0, 8'h55, 8'hDB, 0}, 0};
        vecs[2]  = '{0, 3, '{10'h1C0, 10'h1C0, 10'h1C0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0}, 0};
        vecs[3]  = '{0, 5, '{10'h17E, 10'h1DB, 10'h141, 10'h142, 10'h1C0, 0, 0, 0, 0, 0, 0, 0}, 3, '{8'h7E, 8'h41, 8'h42, 0}, 1};
        vecs[4]  = '{0, 5, '{10'h110, 10'h111, 10'h200, 10'h112, 10'h1C0, 0, 0, 0, 0, 0, 0, 0}, 3, '{8'h10, 8'h11, 8'h12, 0}, 1};
        vecs[5]  = '{1, 7, '{10'h110, 10'h111, 10'h112, 10'h113, 10'h114, 10'h115, 10'h1C0, 0, 0, 0, 0, 0}, 4, '{8'h10, 8'h11, 8'h12, 8'h13}, 1};
        vecs[6]  = '{0, 4, '{10'h1C0, 10'h1DB, 10'h1C0, 10'h1C0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0}, 0};
        vecs[7]  = '{0, 2, '{10'h1AB, 10'h1C0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, '{8'hAB, 0, 0, 0}, 0};
        vecs[8]  = '{0, 4, '{10'h200, 10'h1C0, 10'h133, 10'h1C0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, '{8'h33, 0, 0, 0}, 0};
        vecs[9]  = '{0, 4, '{10'h1DB, 10'h1DB, 10'h1DC, 10'h1C0, 0, 0, 0, 0, 0, 0, 0, 0}, 2, '{8'hDB, 8'hDC, 0, 0}, 1};
        vecs[10] = '{0, 2, '{10'h101, 10'h3C0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, '{8'h01, 0, 0, 0}, 1};
        vecs[11] = '{1, 5, '{10'h1A1, 10'h1A2, 10'h1A3, 10'h1A4, 10'h1C0, 0, 0, 0, 0, 0, 0, 0}, 4, '{8'hA1, 8'hA2, 8'hA3, 8'hA4}, 0};

        foreach (vecs[v]) begin
            sel = vecs[v].sel;
            bx  = (sel == 0) ? rx0.size() : rx1.size();
            bfd = n_fd[sel];
            bbf = n_bf[sel];
            rand_ready = 1'b0;
            m_tready   = 1'b1;
            toks.delete();
            for (int i = 0; i < vecs[v].n_in; i++) toks.push_back(vecs[v].in_tok[i]);
            exp_q.delete();
            for (int i = 0; i < vecs[v].n_out; i++)
                exp_q.push_back({vecs[v].user && (i == vecs[v].n_out - 1),
                                 i == vecs[v].n_out - 1, vecs[v].out_b[i]});
            exp_good = (vecs[v].n_out > 0 && !vecs[v].user) ? 1 : 0;
            exp_bad  = (vecs[v].n_out > 0 &&  vecs[v].user) ? 1 : 0;
            sendAll(sel);
            compareStream(sel, bx, bfd, bbf, $sformatf("vec%0d", v));
        end

        // A lone data byte stays in the hold register until the next byte arrives.
        bx = rx0.size(); bfd = n_fd[0]; bbf = n_bf[0];
        applyStimulus(0, 10'h101);
        repeat (3) tick();
        checkOutput("hold_latency_idle", m_tvalid[0], 0);
        applyStimulus(0, 10'h102);
        checkOutput("hold_latency_emit", {m_tvalid[0], m_tdata[0]}, {1'b1, 8'h01});
        applyStimulus(0, 10'h1C0);
        drain(0);
        toks = '{10'h101, 10'h102, 10'h1C0};
        buildExpected(BIG_LEN);
        compareStream(0, bx, bfd, bbf, "hold_latency");

        // Backpressure mid-frame: input stalls and the output byte holds.
        bx = rx0.size(); bfd = n_fd[0]; bbf = n_bf[0];
        applyStimulus(0, 10'h101);
        applyStimulus(0, 10'h102);
        applyStimulus(0, 10'h103);
        m_tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_s_tready", s_tready[0], 0);
            checkOutput("stall_data", {m_tvalid[0], m_tdata[0]}, {1'b1, 8'h02});
            tick();
        end
        m_tready = 1'b1;
        for (int i = 4; i <= 8; i++) applyStimulus(0, {2'b01, 8'(i)});
        applyStimulus(0, 10'h1C0);
        drain(0);
        toks = '{10'h101, 10'h102, 10'h103, 10'h104, 10'h105, 10'h106, 10'h107, 10'h108, 10'h1C0};
        buildExpected(BIG_LEN);
        compareStream(0, bx, bfd, bbf, "stall_frame");

        // Reset mid-frame discards everything, then a clean frame decodes.
        applyStimulus(0, 10'h101);
        applyStimulus(0, 10'h102);
        applyStimulus(0, 10'h103);
        m_tready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_frame_tvalid", {m_tvalid[0], fd[0], bf[0]}, 0);
        checkOutput("rst_counts", {gcnt[0], bcnt[0]}, 0);
        tot_good[0] = 0; tot_good[1] = 0;
        tot_bad[0]  = 0; tot_bad[1]  = 0;
        m_tready = 1'b1;
        bx = rx0.size(); bfd = n_fd[0]; bbf = n_bf[0];
        toks = '{10'h1C0, 10'h1AA, 10'h1BB, 10'h1C0};
        sendAll(0);
        buildExpected(BIG_LEN);
        compareStream(0, bx, bfd, bbf, "after_reset");

        // Randomized traffic with random downstream readiness.
        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 1);
            bx  = (sel == 0) ? rx0.size() : rx1.size();
            bfd = n_fd[sel];
            bbf = n_bf[sel];
            toks.delete();
            for (int i = 0; i < int'($urandom_range(1, 14)); i++) begin
                r  = $urandom_range(0, 15);
                rb = 8'($urandom_range(0, 255));
                case (r)
                    0, 1:    toks.push_back(10'h1C0);
                    2:       toks.push_back(10'h1DB);
                    3:       toks.push_back(10'h1DC);
                    4:       toks.push_back(10'h1DD);
                    5:       toks.push_back(10'h200);
                    6:       toks.push_back({2'b11, rb});
                    default: toks.push_back({2'b01, rb});
                endcase
            end
            toks.push_back(10'h1C0);
            buildExpected((sel == 0) ? BIG_LEN : SMALL_LEN);
            rand_ready = 1'b1;
            sendAll(sel);
            compareStream(sel, bx, bfd, bbf, $sformatf("rand%0d", it));
        end

        for (int k = 0; k < 2; k++) begin
`ifdef SLIP_FRAME_COUNT_EN
            checkOutput("good_count", gcnt[k], tot_good[k]);
            checkOutput("bad_count", bcnt[k], tot_bad[k]);
`else
            checkOutput("good_count", gcnt[k], 0);
            checkOutput("bad_count", bcnt[k], 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
